// File: rtl/cmp_stream_n.sv
// -----------------------------------------------------------------------------
// cmp_stream_n
//
// Streaming N-bit magnitude comparator with valid/ready flow control on both
// sides. Each accepted (a, b) pair produces one registered one-hot
// less/equal/greater result on the following cycle. A per-sample sgn bit
// selects two's-complement or unsigned ordering. Three saturating counters
// tally the outcomes of accepted samples.
//
// Parameters
//   N      operand width, N >= 2
//   CNT_W  statistics counter width, CNT_W >= 2
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   a/b/sgn carry a sample
//   in_ready   sample is accepted this cycle (= !out_valid || out_ready)
//   a, b       operands
//   sgn        1 = two's complement, 0 = unsigned (sampled with a/b)
//   clr        synchronous clear of the three counters
//   out_valid  l/e/h hold a result
//   out_ready  downstream takes the result
//   l, e, h    A < B, A == B, A > B (one-hot while out_valid)
//   lt_cnt, eq_cnt, gt_cnt   saturating outcome counters
// -----------------------------------------------------------------------------
module cmp_stream_n #(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             sgn,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             l,
  output logic             e,
  output logic             h,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic acc;

  // Operands remapped so a plain unsigned compare gives the requested order.
  logic [N-1:0] a_ord;
  logic [N-1:0] b_ord;
  logic         cmp_lt;
  logic         cmp_eq;
  logic         cmp_gt;

  // Result register, packed as {l, e, h}.
  logic [2:0] res_q, res_d;

  logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;

  // Clear first, then a saturating increment, so a clr/accept collision
  // leaves the matching counter at 1.
  function automatic logic [CNT_W-1:0] cnt_next(
    input logic [CNT_W-1:0] cur,
    input logic             clr_i,
    input logic             hit
  );
    logic [CNT_W-1:0] base;
    base = clr_i ? '0 : cur;
    if (hit && (base != {CNT_W{1'b1}})) begin
      base = base + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return base;
  endfunction

  // ---------------------------------------------------------------------------
  // Comparison datapath
  // ---------------------------------------------------------------------------
  // Flipping the sign bit maps two's-complement order onto unsigned order:
  // the most negative value becomes 0 and the most positive becomes all-ones.
  assign a_ord = {a[N-1] ^ sgn, a[N-2:0]};
  assign b_ord = {b[N-1] ^ sgn, b[N-2:0]};

  assign cmp_lt = (a_ord <  b_ord);
  assign cmp_eq = (a_ord == b_ord);
  assign cmp_gt = !cmp_lt && !cmp_eq;

  // ---------------------------------------------------------------------------
  // Output-stage FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output-stage FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each combinational process assigns a default first so no path
  // leaves a variable unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (acc) state_d = ST_FULL;
      ST_FULL: begin
        // A stalled FULL stays FULL; a drained FULL refills only on accept.
        if (out_ready && !acc) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output-stage FSM: outputs
  // ---------------------------------------------------------------------------
  // in_ready deliberately ignores in_valid so upstream can use it to decide
  // whether to present a sample without a combinational loop.
  always_comb begin
    out_valid = (state_q == ST_FULL);
    in_ready  = !out_valid || out_ready;
  end

  assign acc = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Result and counter next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    res_d    = res_q;
    lt_cnt_d = cnt_next(lt_cnt_q, clr, acc && cmp_lt);
    eq_cnt_d = cnt_next(eq_cnt_q, clr, acc && cmp_eq);
    gt_cnt_d = cnt_next(gt_cnt_q, clr, acc && cmp_gt);
    // The result only moves on accept, so it stays frozen while stalled and
    // keeps its last value while EMPTY.
    if (acc) begin
      res_d = {cmp_lt, cmp_eq, cmp_gt};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q    <= '0;
      lt_cnt_q <= '0;
      eq_cnt_q <= '0;
      gt_cnt_q <= '0;
    end else begin
      res_q    <= res_d;
      lt_cnt_q <= lt_cnt_d;
      eq_cnt_q <= eq_cnt_d;
      gt_cnt_q <= gt_cnt_d;
    end
  end

  assign l      = res_q[2];
  assign e      = res_q[1];
  assign h      = res_q[0];
  assign lt_cnt = lt_cnt_q;
  assign eq_cnt = eq_cnt_q;
  assign gt_cnt = gt_cnt_q;

endmodule

// File: tb/tb_cmp_stream_n.sv
// -----------------------------------------------------------------------------
// tb_cmp_stream_n
//
// Two instances of cmp_stream_n share clk/rst:
//   dut8  : N=8,  CNT_W=2  -- directed reset/compare/sign/back-pressure/
//                             saturation/clear-collision steps
//   dut32 : N=32, CNT_W=16 -- random soak against a queue-based reference
// Inputs change 1 ns after the rising edge; outputs are sampled before the
// next rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cmp_stream_n;

  logic clk;
  logic rst;

  // ---- dut8 signals ----
  logic       in_valid8, in_ready8, sgn8, clr8, out_valid8, out_ready8;
  logic [7:0] a8, b8;
  logic       l8, e8, h8;
  logic [1:0] lt8, eq8, gt8;

  // ---- dut32 signals ----
  logic        in_valid32, in_ready32, sgn32, clr32, out_valid32, out_ready32;
  logic [31:0] a32, b32;
  logic        l32, e32, h32;
  logic [15:0] lt32, eq32, gt32;

  int vectors;
  int miscompares;

  cmp_stream_n #(.N(8), .CNT_W(2)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sgn(sgn8), .clr(clr8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .l(l8), .e(e8), .h(h8),
    .lt_cnt(lt8), .eq_cnt(eq8), .gt_cnt(gt8)
  );

  cmp_stream_n #(.N(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .sgn(sgn32), .clr(clr32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .l(l32), .e(e32), .h(h32),
    .lt_cnt(lt32), .eq_cnt(eq32), .gt_cnt(gt32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic s);
    in_valid8 = 1'b1;
    a8        = av;
    b8        = bv;
    sgn8      = s;
  endtask

  // Reference ordering: {l,e,h} from plain integer arithmetic.
  function automatic logic [2:0] ref_cmp(input logic [31:0] av, input logic [31:0] bv,
                                         input logic s);
    longint x, y;
    if (s) begin
      x = longint'($signed(av));
      y = longint'($signed(bv));
    end else begin
      x = longint'({32'd0, av});
      y = longint'({32'd0, bv});
    end
    if (x < y)       return 3'b100;
    else if (x == y) return 3'b010;
    else             return 3'b001;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Soak state
  logic [2:0] sb_q[$];
  logic [2:0] exp_res;
  int         tally_lt, tally_eq, tally_gt;
  int         accepted;
  int         cycles;
  logic       exp_ready;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid8   = 1'b0; a8 = '0; b8 = '0; sgn8 = 1'b0; clr8 = 1'b0; out_ready8 = 1'b0;
    in_valid32  = 1'b0; a32 = '0; b32 = '0; sgn32 = 1'b0; clr32 = 1'b0; out_ready32 = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid8), 32'd0);
    check("rst_lhe",       32'({l8, e8, h8}), 32'd0);
    check("rst_in_ready",  32'(in_ready8), 32'd1);
    rst = 1'b0;

    // ---------------- reset mid-stream ----------------
    send8(8'h11, 8'h10, 1'b0);
    tick();
    in_valid8 = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid8), 32'd1);
    check("pre_rst_gt",        32'(gt8), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid8), 32'd0);
    check("mid_rst_lhe",       32'({l8, e8, h8}), 32'd0);
    check("mid_rst_cnts",      32'({lt8, eq8, gt8}), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready8), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_out_valid", 32'(out_valid8), 32'd0);

    // ---------------- basic unsigned compare ----------------
    out_ready8 = 1'b1;
    send8(8'h05, 8'h03, 1'b0); tick();
    check("basic_gt_valid", 32'(out_valid8), 32'd1);
    check("basic_gt",  32'({l8, e8, h8}), 32'b001);
    send8(8'h03, 8'h05, 1'b0); tick();
    check("basic_lt",  32'({l8, e8, h8}), 32'b100);
    send8(8'h7F, 8'h7F, 1'b0); tick();
    check("basic_eq",  32'({l8, e8, h8}), 32'b010);
    in_valid8 = 1'b0; tick();
    check("basic_drain", 32'(out_valid8), 32'd0);
    check("basic_cnts",  32'({lt8, eq8, gt8}), 32'({2'd1, 2'd1, 2'd1}));

    // ---------------- signed mode ----------------
    send8(8'h80, 8'h01, 1'b0); tick();
    check("uns_80_01", 32'({l8, e8, h8}), 32'b001);
    send8(8'h80, 8'h01, 1'b1); tick();
    check("sgn_80_01", 32'({l8, e8, h8}), 32'b100);
    send8(8'hFF, 8'h00, 1'b1); tick();
    check("sgn_ff_00", 32'({l8, e8, h8}), 32'b100);
    send8(8'h7F, 8'h80, 1'b1); tick();
    check("sgn_7f_80", 32'({l8, e8, h8}), 32'b001);
    in_valid8 = 1'b0; tick();
    check("sgn_cnts", 32'({lt8, eq8, gt8}), 32'({2'd3, 2'd1, 2'd3}));

    // ---------------- back-pressure ----------------
    out_ready8 = 1'b0;
    send8(8'h20, 8'h30, 1'b0); tick();
    check("bp_first_valid", 32'(out_valid8), 32'd1);
    send8(8'h40, 8'h40, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready",  32'(in_ready8), 32'd0);
      check("bp_out_valid", 32'(out_valid8), 32'd1);
      check("bp_lhe",       32'({l8, e8, h8}), 32'b100);
      tick();
    end
    check("bp_eq_not_taken", 32'(eq8), 32'd1);
    out_ready8 = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready8), 32'd1);
    tick();
    check("bp_next_valid", 32'(out_valid8), 32'd1);
    check("bp_next_lhe",   32'({l8, e8, h8}), 32'b010);
    check("bp_next_eq",    32'(eq8), 32'd2);
    in_valid8 = 1'b0; tick();
    check("bp_drain", 32'(out_valid8), 32'd0);

    // ---------------- saturation ----------------
    clr8 = 1'b1; tick(); clr8 = 1'b0;
    check("clr_cnts", 32'({lt8, eq8, gt8}), 32'd0);
    send8(8'h55, 8'h55, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("sat_eq", 32'(eq8), (i > 3) ? 32'd3 : 32'(i));
    end
    in_valid8 = 1'b0; tick();

    // ---------------- clear collision ----------------
    send8(8'h09, 8'h02, 1'b0);
    tick(); tick(); tick();
    check("coll_gt_pre", 32'(gt8), 32'd3);
    clr8 = 1'b1;
    send8(8'h02, 8'h01, 1'b0);
    tick();
    clr8 = 1'b0; in_valid8 = 1'b0;
    check("coll_cnts",  32'({lt8, eq8, gt8}), 32'({2'd0, 2'd0, 2'd1}));
    check("coll_valid", 32'(out_valid8), 32'd1);
    check("coll_lhe",   32'({l8, e8, h8}), 32'b001);
    tick();

    // ---------------- random soak, N=32 ----------------
    tally_lt = 0; tally_eq = 0; tally_gt = 0;
    accepted = 0; cycles = 0;
    while (accepted < 10000 && cycles < 60000) begin
      in_valid32  = ($urandom_range(3) != 0);
      out_ready32 = ($urandom_range(3) != 0);
      sgn32       = $urandom_range(1) == 1;
      a32         = $urandom;
      case ($urandom_range(7))
        0:       b32 = a32;
        1:       b32 = a32 ^ 32'h8000_0000;
        2:       b32 = a32 + 32'd1;
        default: b32 = $urandom;
      endcase
      #1;
      // The output holds at most one result: queue depth is occupancy.
      exp_ready = (sb_q.size() == 0) || out_ready32;
      check("soak_out_valid", 32'(out_valid32), 32'(sb_q.size() != 0));
      check("soak_in_ready",  32'(in_ready32), 32'(exp_ready));
      if (sb_q.size() != 0) begin
        check("soak_lhe", 32'({l32, e32, h32}), 32'(sb_q[0]));
        if (out_ready32) void'(sb_q.pop_front());
      end
      if (in_valid32 && exp_ready) begin
        exp_res = ref_cmp(a32, b32, sgn32);
        sb_q.push_back(exp_res);
        accepted++;
        if (exp_res == 3'b100)      tally_lt++;
        else if (exp_res == 3'b010) tally_eq++;
        else                        tally_gt++;
      end
      tick();
      cycles++;
    end
    check("soak_budget", 32'(accepted), 32'd10000);
    in_valid32 = 1'b0;
    #1;
    check("soak_lt_cnt", 32'(lt32), 32'(sat16(tally_lt)));
    check("soak_eq_cnt", 32'(eq32), 32'(sat16(tally_eq)));
    check("soak_gt_cnt", 32'(gt32), 32'(sat16(tally_gt)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
